// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the normalise/round datapath: field widths,
// exponent limits, flag layout and the stage payload carried between registers.
package fp_pkg;
    localparam int FRAC_W    = 23;
    localparam int EXPF_W    = 8;
    localparam int EXP_MAX   = 255;
    localparam int FP_BIAS   = 127;
    localparam int EXP_W_DEF = 10;
    // Internal exponent is wider than the port so normalise/round adjustments never wrap.
    localparam int XEXP_W    = 16;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
        logic zero;
    } fp_flags_t;

    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;
        logic [31:0]       mant;
        logic              special;
        logic [31:0]       special_val;
    } stage_t;
endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even, range check and IEEE single packing
// for a mantissa already normalised so the hidden one sits at bit 30.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_LIMIT = EXP_MAX
) (
    input  logic              sign,
    input  logic [XEXP_W-1:0] exp,
    input  logic [31:0]       mant,
    output logic [31:0]       result,
    output fp_flags_t         flags
);
    logic              lsb, guard, rnd, sticky;
    logic              up, inexact, zero, carry;
    logic [FRAC_W-1:0] frac;
    logic [XEXP_W-1:0] exp_r;
    logic              too_big, too_small;

    // A normalised non-zero value always has bit 30 set, so both top bits clear means zero.
    assign zero    = ~|mant[31:30];
    assign lsb     = mant[7];
    assign guard   = mant[6];
    assign rnd     = mant[5];
    assign sticky  = |mant[4:0];
    assign up      = guard & (lsb | rnd | sticky);
    assign inexact = guard | rnd | sticky;

    // Carry out of the fraction alone equals carry out of {1,fraction}; the fraction is then zero.
    assign {carry, frac} = {1'b0, mant[29:7]} + 24'(up);
    assign exp_r         = exp + XEXP_W'(carry);

    assign too_big   = ~exp_r[XEXP_W-1] & (exp_r >= XEXP_W'(EXP_LIMIT));
    assign too_small = exp_r[XEXP_W-1] | (exp_r == '0);

    always_comb begin
        result        = {sign, exp_r[EXPF_W-1:0], frac};
        flags         = '0;
        flags.inexact = inexact;
        if (zero) begin
            result     = {sign, 31'h0};
            flags      = '0;
            flags.zero = 1'b1;
        end else if (too_big) begin
            result        = {sign, 8'hFF, 23'h0};
            flags         = '0;
            flags.ovf     = 1'b1;
            flags.inexact = 1'b1;
        end else if (too_small) begin
            result        = {sign, 31'h0};
            flags.ovf     = 1'b0;
            flags.unf     = 1'b1;
            flags.zero    = 1'b1;
            flags.inexact = 1'b1;
        end
    end
endmodule

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) cnt = 6'(31 - i);
        end
    end
endmodule

// File: rtl/fp32_norm_round.sv
// Three-stage normalise/round/pack for the FP32 adder: S1 captures inputs and
// leading-zero count, S2 shifts, S3 rounds and drives the outputs.
module fp32_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int BIAS  = FP_BIAS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [31:0]      in_mant,
    input  logic             in_special,
    input  logic [31:0]      in_special_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags
);
    logic        en;
    logic        v1, v2;
    stage_t      s1, s2, s2_nxt;
    logic [5:0]  lz_in, s1_lz, shamt;
    logic [31:0] rnd_result;
    fp_flags_t   rnd_flags;

    // Whole pipe stalls together; bubbles are carried rather than collapsed.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    lzc32 u_lzc (
        .a   (in_mant),
        .cnt (lz_in)
    );

    always_comb begin
        s2_nxt = s1;
        shamt  = s1_lz - 6'd1;
        if (s1_lz == 6'd0) begin
            s2_nxt.mant = {1'b0, s1.mant[31:2], s1.mant[1] | s1.mant[0]};
            s2_nxt.exp  = s1.exp + XEXP_W'(1);
        end else if (s1_lz != 6'd32) begin
            s2_nxt.mant = s1.mant << shamt;
            s2_nxt.exp  = s1.exp - XEXP_W'(shamt);
        end
    end

    fp_round_rne #(
        .EXP_LIMIT (2 * BIAS + 1)
    ) u_round (
        .sign   (s2.sign),
        .exp    (s2.exp),
        .mant   (s2.mant),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            s1         <= '0;
            s1_lz      <= '0;
            s2         <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (en) begin
            v1             <= in_valid;
            s1.sign        <= in_sign;
            s1.exp         <= XEXP_W'($signed(in_exp));
            s1.mant        <= in_mant;
            s1.special     <= in_special;
            s1.special_val <= in_special_val;
            s1_lz          <= lz_in;

            v2 <= v1;
            s2 <= s2_nxt;

            out_valid  <= v2;
            out_result <= s2.special ? s2.special_val : rnd_result;
            out_flags  <= s2.special ? 4'h0 : rnd_flags;
        end
    end
endmodule

// File: tb/tb_fp32_norm_round.sv
// Self-checking bench for fp32_norm_round: directed vectors, latency,
// backpressure, mid-stream reset and randomized traffic against a reference model.
module tb_fp32_norm_round;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [31:0] in_mant = '0;
    logic        in_special = 1'b0;
    logic [31:0] in_special_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int checks = 0;
    int fails  = 0;

    fp32_norm_round dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags)
    );

    always #5 clk = ~clk;

    // Exact round-to-nearest-even of the integer magnitude, returns {flags, result}.
    function automatic logic [35:0] ref_model(input logic s, input logic signed [9:0] e,
                                              input logic [31:0] m, input logic sp,
                                              input logic [31:0] sv);
        int     p, k, eo;
        longint q, rem, half;
        logic   inx, up;
        inx = 1'b0;
        if (sp) return {4'b0000, sv};
        if (m == 0) return {4'b0001, s, 31'h0};
        p = 31;
        while (!m[p]) p--;
        k = p - 23;
        if (k <= 0) begin
            q = longint'(m) << (-k);
        end else begin
            q    = longint'(m) >> k;
            rem  = longint'(m) & ((64'sd1 << k) - 1);
            half = 64'sd1 << (k - 1);
            up   = (rem > half) || (rem == half && q[0]);
            inx  = (rem != 0);
            if (up) q = q + 1;
        end
        eo = int'(e) + p - 30;
        if (q == (64'sd1 << 24)) begin
            q  = q >> 1;
            eo = eo + 1;
        end
        if (eo >= 255) return {4'b1010, s, 8'hFF, 23'h0};
        if (eo <= 0) return {4'b0111, s, 31'h0};
        return {2'b00, inx, 1'b0, s, eo[7:0], q[22:0]};
    endfunction

    task automatic rand_beat();
        case ($urandom_range(0, 3))
            0: in_exp = 10'($urandom);
            1: in_exp = 10'($urandom_range(0, 8));
            2: in_exp = 10'($urandom_range(245, 262));
            default: in_exp = 10'($urandom_range(100, 160));
        endcase
        in_sign    = 1'($urandom);
        in_mant    = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 15) == 0) in_mant = '0;
        in_special = ($urandom_range(0, 15) == 0);
        in_special_val = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", out_result); end
        checks++;
        if (out_flags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %h expected 0", out_flags); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int n;
        in_sign = 1'b0; in_exp = 10'd127; in_mant = 32'h4000_0000; in_special = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 3) begin fails++; $display("FAIL latency: got %0d cycles expected 3", n); end
        checks++;
        if (out_result !== 32'h3F80_0000) begin fails++; $display("FAIL latency_result: got %h expected 3f800000", out_result); end
        checks++;
        if (out_flags !== 4'h0) begin fails++; $display("FAIL latency_flags: got %h expected 0", out_flags); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_single: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        logic        ts [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        int          te [11] = '{127, 127, 127, 127, 127, 127, 254, 1, 127, 0, 127};
        logic [31:0] tm [11] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0080, 32'h4000_0040,
                                 32'h4000_00C0, 32'h7FFF_FFC0, 32'h8000_0000, 32'h2000_0000,
                                 32'h0000_0000, 32'h1234_5678, 32'h4000_0000};
        logic        tsp[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [31:0] tr [11] = '{32'h3F80_0000, 32'h4000_0000, 32'h3400_0000, 32'h3F80_0000,
                                 32'h3F80_0002, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000,
                                 32'h8000_0000, 32'h7FC0_0000, 32'hBF80_0000};
        logic [3:0]  tf [11] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'hA, 4'h7, 4'h1, 4'h0, 4'h0};
        int sent = 0, got = 0, cyc = 0;
        out_ready = 1'b1;
        while (got < 11 && cyc < 60) begin
            if (sent < 11) begin
                in_sign = ts[sent]; in_exp = 10'(te[sent]); in_mant = tm[sent];
                in_special = tsp[sent]; in_special_val = 32'h7FC0_0000; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                checks++;
                if (out_result !== tr[got]) begin
                    fails++; $display("FAIL directed_result[%0d]: got %h expected %h", got, out_result, tr[got]);
                end
                checks++;
                if (out_flags !== tf[got]) begin
                    fails++; $display("FAIL directed_flags[%0d]: got %h expected %h", got, out_flags, tf[got]);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 11) begin fails++; $display("FAIL directed_count: got %0d results expected 11", got); end
    endtask

    task automatic test_backpressure();
        logic [35:0] q[$];
        logic [35:0] exp_v, held;
        logic        held_v = 1'b0, acc = 1'b0;
        int          sent = 0, got = 0, cyc = 0, stalls = 0, extra = 0;
        while (got < 5 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            if (!(in_valid && !acc)) begin
                if (sent < 5) begin rand_beat(); in_valid = 1'b1; end
                else in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_model(in_sign, $signed(in_exp), in_mant, in_special, in_special_val));
                sent++;
            end
            if (held_v && out_valid) begin
                checks++;
                if ({out_flags, out_result} !== held) begin
                    fails++; $display("FAIL stall_stable: got %h expected %h", {out_flags, out_result}, held);
                end
            end
            if (out_valid && !out_ready) begin
                stalls++;
                checks++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            end
            held_v = out_valid && !out_ready;
            held   = {out_flags, out_result};
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL bp_extra: got %h expected no result", out_result);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_flags, out_result} !== exp_v) begin
                        fails++; $display("FAIL bp_result[%0d]: got %h expected %h", got, {out_flags, out_result}, exp_v);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        @(posedge clk); #1;
        checks++;
        if (got !== 5 || extra !== 0) begin
            fails++; $display("FAIL bp_count: got %0d results and %0d extra expected 5 and 0", got, extra);
        end
        checks++;
        if (stalls !== 4) begin fails++; $display("FAIL bp_stall_cycles: got %0d expected 4", stalls); end
    endtask

    task automatic test_random(input int n);
        logic [35:0] q[$];
        logic [35:0] exp_v;
        logic        acc = 1'b0;
        int          sent = 0, got = 0, cyc = 0;
        while (got < n && cyc < 20000) begin
            if (!(in_valid && !acc)) begin
                if (sent < n && $urandom_range(0, 3) != 0) begin rand_beat(); in_valid = 1'b1; end
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_model(in_sign, $signed(in_exp), in_mant, in_special, in_special_val));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra: got %h expected no result", out_result);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_flags, out_result} !== exp_v) begin
                        fails++; $display("FAIL rand_result[%0d]: got %h expected %h", got, {out_flags, out_result}, exp_v);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== n) begin fails++; $display("FAIL rand_timeout: got %0d results expected %0d", got, n); end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b1;
        in_sign = 1'b0; in_exp = 10'd127; in_mant = 32'h4000_0000; in_special = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_mant = 32'h8000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_result !== 32'h0 || out_flags !== 4'h0) begin
            fails++; $display("FAIL midrst_outputs: got %h/%h expected 00000000/0", out_result, out_flags);
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        @(posedge clk); #1;
        checks++;
        if (stale !== 0) begin fails++; $display("FAIL midrst_stale: got %0d results expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_random(300);
        test_reset_midstream();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
